// File: rtl/spraid_sched_if.sv
// Bundle of command, response and channel-engine signals around the scheduler.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready on commands, rsp_valid/rsp_ready on responses.
interface spraid_sched_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_mode;
    logic [1:0]  cmd_chan;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  ch_start;
    logic        ch_write;
    logic [31:0] ch_tx;
    logic [3:0]  ch_done;
    logic [31:0] ch_rx;
    logic [3:0]  ch_fail;
    logic [3:0]  fail_clr;

    // Front-end and channel engines drive commands, completions and clears.
    modport master (
        output cmd_valid, cmd_write, cmd_mode, cmd_chan, cmd_data,
        output rsp_ready, ch_done, ch_rx, fail_clr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  ch_start, ch_write, ch_tx, ch_fail
    );

    // Scheduler view.
    modport slave (
        input  cmd_valid, cmd_write, cmd_mode, cmd_chan, cmd_data,
        input  rsp_ready, ch_done, ch_rx, fail_clr,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output ch_start, ch_write, ch_tx, ch_fail
    );
endinterface

// File: rtl/spraid_sched.sv
// Command scheduler: fans one 32-bit command out to four SPI channel engines and merges completions.
// Latency: start pulse the cycle after accept; response the cycle after the last done, or after TIMEOUT wait cycles.
// Backpressure: cmd_ready only in IDLE; the response is held stable until rsp_ready.
module spraid_sched #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    spraid_sched_if.slave bus
);
    localparam int unsigned       TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] M_STRIPE = 2'd0;
    localparam logic [1:0] M_MIRROR = 2'd1;
    localparam logic [1:0] M_SINGLE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          write_q, write_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    chan_q, chan_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    pend_q, pend_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   rx_q, rx_d;
    logic [31:0]   tx_q, tx_d;
    logic [3:0]    start_q, start_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [3:0]    fail_q, fail_d;

    logic          cmd_ready;
    logic [3:0]    acc_mask;
    logic          acc_err;
    logic [3:0]    done_hit;
    logic [3:0]    pend_left;
    logic [31:0]   rx_cap;
    logic [7:0]    ref_byte;
    logic          ref_found;
    logic          mir_mismatch;
    logic [31:0]   rd_data;

    assign cmd_ready     = (state_q == S_IDLE) & ~wb_rst_i;
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.ch_start  = start_q;
    assign bus.ch_write  = write_q;
    assign bus.ch_tx     = tx_q;
    assign bus.ch_fail   = fail_q;

    // Channel mask and immediate-error decision for the command on offer.
    always_comb begin
        acc_mask = 4'h0;
        acc_err  = 1'b0;
        case (bus.cmd_mode)
            M_STRIPE: begin
                acc_mask = 4'hF;
                acc_err  = |fail_q;
            end
            M_MIRROR: begin
                acc_mask = ~fail_q;
                acc_err  = (fail_q == 4'hF);
            end
            M_SINGLE: begin
                acc_mask = 4'b0001 << bus.cmd_chan;
                acc_err  = fail_q[bus.cmd_chan];
            end
            default: acc_err = 1'b1;
        endcase
    end

    // Completions that count this cycle and the receive bytes including them.
    always_comb begin
        done_hit  = (state_q == S_WAIT) ? (bus.ch_done & pend_q) : 4'h0;
        pend_left = pend_q & ~done_hit;
        rx_cap    = rx_q;
        for (int i = 0; i < 4; i++) begin
            if (done_hit[i]) begin
                rx_cap[8*i +: 8] = bus.ch_rx[8*i +: 8];
            end
        end
    end

    // Read data assembly and mirror consistency check over the masked channels.
    always_comb begin
        ref_byte     = 8'h00;
        ref_found    = 1'b0;
        mir_mismatch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mask_q[i] && !ref_found) begin
                ref_byte  = rx_cap[8*i +: 8];
                ref_found = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mask_q[i] && (rx_cap[8*i +: 8] != ref_byte)) begin
                mir_mismatch = 1'b1;
            end
        end
        case (mode_q)
            M_STRIPE: rd_data = rx_cap;
            M_MIRROR: rd_data = {24'h0, ref_byte};
            default:  rd_data = {24'h0, rx_cap[{chan_q, 3'b000} +: 8]};
        endcase
    end

    // Scheduler state machine; failure clears apply every cycle, timeout sets win over them.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        mode_d      = mode_q;
        chan_d      = chan_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        timer_d     = timer_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        start_d     = 4'h0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        fail_d      = fail_q & ~bus.fail_clr;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    write_d = bus.cmd_write;
                    mode_d  = bus.cmd_mode;
                    chan_d  = bus.cmd_chan;
                    if (acc_err) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'h0;
                    end else begin
                        state_d = S_LAUNCH;
                        mask_d  = acc_mask;
                        start_d = acc_mask;
                        tx_d    = (bus.cmd_mode == M_STRIPE) ? bus.cmd_data
                                                             : {4{bus.cmd_data[7:0]}};
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                pend_d  = mask_q;
                timer_d = '0;
            end
            S_WAIT: begin
                pend_d  = pend_left;
                rx_d    = rx_cap;
                timer_d = timer_q + TW'(1);
                if (pend_left == 4'h0) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~write_q & (mode_q == M_MIRROR) & mir_mismatch;
                    rsp_data_d  = write_q ? 32'h0 : rd_data;
                end else if (timer_q == TMAX) begin
                    // Channels still outstanding at expiry are marked failed.
                    state_d     = S_RESP;
                    fail_d      = fail_d | pend_left;
                    pend_d      = 4'h0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 32'h0;
                end
            end
            default: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            mode_q      <= 2'd0;
            chan_q      <= 2'd0;
            mask_q      <= 4'h0;
            pend_q      <= 4'h0;
            timer_q     <= '0;
            rx_q        <= 32'h0;
            tx_q        <= 32'h0;
            start_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
            fail_q      <= 4'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            mode_q      <= mode_d;
            chan_q      <= chan_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            timer_q     <= timer_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            fail_q      <= fail_d;
        end
    end
endmodule

// File: tb/tb_spraid_sched.sv
// Bench for spraid_sched: directed scenarios plus randomized commands against an outcome model.
// Latency: model predicts the response cycle from per-channel completion times.
// Backpressure: holds rsp_ready low for a random number of cycles and checks stability.
module tb_spraid_sched;
    localparam int          TO    = 8;
    localparam logic [7:0]  NEVER = 8'hFF;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] model_fail = 4'h0;

    spraid_sched_if bus();

    spraid_sched #(.TIMEOUT(TO)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic pulse_clr(input logic [3:0] v);
        bus.fail_clr = v;
        tick;
        bus.fail_clr = 4'h0;
        model_fail = model_fail & ~v;
    endtask

    // One command: the model works out mask, completion cycles and the response, then the DUT is driven.
    task automatic run_cmd(input logic wr, input logic [1:0] mode, input logic [1:0] chan,
                           input logic [31:0] data,
                           input logic [3:0][7:0] dly, input logic [3:0][7:0] rx,
                           input logic [3:0][7:0] dly2, input logic [3:0][7:0] rx2,
                           input int hold, input int clr_c, input logic [3:0] clr_v,
                           input string tag);
        logic [3:0]  mask, left;
        logic        imm, exp_e, found, stray, moved, got_e;
        logic [7:0]  ref_b;
        logic [31:0] exp_d, exp_tx, got_d;
        int          exp_r, got_r, last, wait_n;

        imm  = 1'b0;
        mask = 4'h0;
        case (mode)
            2'd0: begin mask = 4'hF; imm = (model_fail != 4'h0); end
            2'd1: begin mask = ~model_fail; imm = (mask == 4'h0); end
            2'd2: begin mask = 4'h1 << chan; imm = model_fail[chan]; end
            default: imm = 1'b1;
        endcase
        if (imm) mask = 4'h0;
        left = 4'h0;
        last = 1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (dly[i] == NEVER || int'(dly[i]) > TO) left[i] = 1'b1;
                else if (int'(dly[i]) + 1 > last) last = int'(dly[i]) + 1;
            end
        end
        exp_d = 32'h0;
        exp_e = 1'b0;
        if (imm) begin
            exp_r = 1;
            exp_e = 1'b1;
        end else if (left != 4'h0) begin
            exp_r = TO + 2;
            exp_e = 1'b1;
        end else begin
            exp_r = last + 1;
            if (!wr) begin
                found = 1'b0;
                ref_b = 8'h0;
                for (int i = 0; i < 4; i++) begin
                    if (mask[i] && !found) begin ref_b = rx[i]; found = 1'b1; end
                end
                case (mode)
                    2'd0: exp_d = rx;
                    2'd1: begin
                        exp_d = {24'h0, ref_b};
                        for (int i = 0; i < 4; i++) if (mask[i] && rx[i] != ref_b) exp_e = 1'b1;
                    end
                    default: exp_d = {24'h0, rx[chan]};
                endcase
            end
        end
        exp_tx = (mode == 2'd0) ? data : {4{data[7:0]}};

        wait_n = 0;
        while (bus.cmd_ready !== 1'b1 && wait_n < 20) begin tick; wait_n++; end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s cmd_ready_idle: got %b want 1", tag, bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_mode  = mode;
        bus.cmd_chan  = chan;
        bus.cmd_data  = data;
        tick;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = $urandom;
        got_r = 0;
        stray = 1'b0;
        for (int c = 1; c <= TO + 20 && got_r == 0; c++) begin
            if (c == 1) begin
                n_checks++;
                if (bus.ch_start !== mask) begin n_fail++; $display("FAIL %s ch_start: got %b want %b", tag, bus.ch_start, mask); end
                n_checks++;
                if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL %s cmd_ready_busy: got %b want 0", tag, bus.cmd_ready); end
                if (!imm) begin
                    n_checks++;
                    if (bus.ch_tx !== exp_tx) begin n_fail++; $display("FAIL %s ch_tx: got %h want %h", tag, bus.ch_tx, exp_tx); end
                    n_checks++;
                    if (bus.ch_write !== wr) begin n_fail++; $display("FAIL %s ch_write: got %b want %b", tag, bus.ch_write, wr); end
                end
            end else if (bus.ch_start !== 4'h0) begin
                stray = 1'b1;
            end
            if (bus.rsp_valid === 1'b1) begin
                got_r = c;
            end else begin
                bus.ch_done  = 4'h0;
                bus.ch_rx    = $urandom;
                bus.fail_clr = (c == clr_c) ? clr_v : 4'h0;
                for (int i = 0; i < 4; i++) begin
                    if (int'(dly[i]) + 1 == c) begin
                        bus.ch_done[i] = 1'b1;
                        bus.ch_rx[8*i +: 8] = rx[i];
                    end else if (dly2[i] != 8'h0 && int'(dly2[i]) + 1 == c) begin
                        bus.ch_done[i] = 1'b1;
                        bus.ch_rx[8*i +: 8] = rx2[i];
                    end
                end
                tick;
            end
        end
        bus.ch_done  = 4'h0;
        bus.fail_clr = 4'h0;

        n_checks++;
        if (got_r != exp_r) begin n_fail++; $display("FAIL %s rsp_cycle: got %0d want %0d", tag, got_r, exp_r); end
        n_checks++;
        if (stray) begin n_fail++; $display("FAIL %s stray_ch_start: got 1 want 0", tag); end
        if (got_r != 0) begin
            n_checks++;
            if (bus.rsp_err !== exp_e) begin n_fail++; $display("FAIL %s rsp_err: got %b want %b", tag, bus.rsp_err, exp_e); end
            n_checks++;
            if (bus.rsp_data !== exp_d) begin n_fail++; $display("FAIL %s rsp_data: got %h want %h", tag, bus.rsp_data, exp_d); end
            got_d = bus.rsp_data;
            got_e = bus.rsp_err;
            moved = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== got_d || bus.rsp_err !== got_e) moved = 1'b1;
            end
            if (hold > 0) begin
                n_checks++;
                if (moved) begin n_fail++; $display("FAIL %s rsp_stable: got moved=1 want 0", tag); end
            end
            bus.rsp_ready = 1'b1;
            tick;
            bus.rsp_ready = 1'b0;
            n_checks++;
            if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s rsp_drop: got %b want 0", tag, bus.rsp_valid); end
            n_checks++;
            if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s cmd_ready_back: got %b want 1", tag, bus.cmd_ready); end
        end
        model_fail = (model_fail & ~((clr_c > 0) ? clr_v : 4'h0)) | left;
        n_checks++;
        if (bus.ch_fail !== model_fail) begin n_fail++; $display("FAIL %s ch_fail: got %b want %b", tag, bus.ch_fail, model_fail); end
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1;
        tick;
        tick;
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.ch_start, bus.rsp_data, bus.ch_tx} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b e=%b s=%b d=%h tx=%h want all 0",
                     bus.rsp_valid, bus.rsp_err, bus.ch_start, bus.rsp_data, bus.ch_tx);
        end
        n_checks++;
        if (bus.ch_fail !== 4'h0) begin n_fail++; $display("FAIL reset_ch_fail: got %b want 0000", bus.ch_fail); end
        wb_rst_i = 1'b0;
        tick;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready); end
        model_fail = 4'h0;
    endtask

    task automatic test_stripe_write;
        run_cmd(1'b1, 2'd0, 2'd0, 32'hA1B2C3D4, {8'd2, 8'd2, 8'd2, 8'd2}, 32'h0, 32'h0, 32'h0,
                0, 0, 4'h0, "stripe_write");
    endtask

    task automatic test_stripe_read_stagger;
        run_cmd(1'b0, 2'd0, 2'd0, 32'h0, {8'd5, 8'd2, 8'd3, 8'd1}, 32'h44332211,
                {8'd0, 8'd0, 8'd0, 8'd4}, 32'h00000099, 0, 0, 4'h0, "stripe_stagger");
    endtask

    task automatic test_timeout;
        run_cmd(1'b0, 2'd0, 2'd0, 32'h0, {8'd2, NEVER, 8'd2, 8'd2}, 32'hDEADBEEF, 32'h0, 32'h0,
                0, 0, 4'h0, "timeout");
        run_cmd(1'b1, 2'd0, 2'd0, 32'h12345678, {8'd1, 8'd1, 8'd1, 8'd1}, 32'h0, 32'h0, 32'h0,
                0, 0, 4'h0, "stripe_after_fail");
    endtask

    task automatic test_mirror_degraded;
        run_cmd(1'b0, 2'd1, 2'd0, 32'h0, {8'd3, NEVER, 8'd1, 8'd2}, 32'h5A005A5A, 32'h0, 32'h0,
                0, 0, 4'h0, "mirror_ok");
        run_cmd(1'b0, 2'd1, 2'd0, 32'h0, {8'd3, NEVER, 8'd1, 8'd2}, 32'h5B005A5A, 32'h0, 32'h0,
                0, 0, 4'h0, "mirror_mismatch");
        run_cmd(1'b1, 2'd1, 2'd0, 32'h000000C3, {8'd1, NEVER, 8'd2, 8'd1}, 32'h0, 32'h0, 32'h0,
                0, 0, 4'h0, "mirror_write");
    endtask

    task automatic test_single_reserved;
        run_cmd(1'b0, 2'd2, 2'd3, 32'h0, {8'd2, NEVER, NEVER, NEVER}, 32'h7E000000, 32'h0, 32'h0,
                5, 0, 4'h0, "single_ch3_bp");
        run_cmd(1'b0, 2'd3, 2'd0, 32'h0, {8'd1, 8'd1, 8'd1, 8'd1}, 32'h0, 32'h0, 32'h0,
                0, 0, 4'h0, "reserved");
        run_cmd(1'b0, 2'd2, 2'd2, 32'h0, {8'd1, 8'd1, 8'd1, 8'd1}, 32'h0, 32'h0, 32'h0,
                0, 0, 4'h0, "single_failed");
    endtask

    task automatic test_reset_mid;
        logic bad;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_mode  = 2'd1;
        bus.cmd_chan  = 2'd0;
        bus.cmd_data  = 32'h0000002C;
        tick;
        bus.cmd_valid = 1'b0;
        tick;
        tick;
        bus.ch_done = 4'b0001;
        bus.ch_rx   = $urandom;
        wb_rst_i    = 1'b1;
        tick;
        bus.ch_done = 4'h0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.ch_start, bus.ch_write, bus.rsp_data, bus.ch_tx} !== 71'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got v=%b e=%b s=%b w=%b d=%h tx=%h want all 0",
                     bus.rsp_valid, bus.rsp_err, bus.ch_start, bus.ch_write, bus.rsp_data, bus.ch_tx);
        end
        n_checks++;
        if (bus.ch_fail !== 4'h0) begin n_fail++; $display("FAIL rstmid_ch_fail: got %b want 0000", bus.ch_fail); end
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_in_reset: got %b want 0", bus.cmd_ready); end
        wb_rst_i    = 1'b0;
        bus.ch_done = 4'hF;
        bus.ch_rx   = $urandom;
        tick;
        bus.ch_done = 4'h0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.rsp_valid !== 1'b0 || bus.ch_start !== 4'h0) bad = 1'b1;
            tick;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL rstmid_late_done: got activity=1 want 0"); end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b want 1", bus.cmd_ready); end
        model_fail = 4'h0;
    endtask

    task automatic test_fail_clr;
        run_cmd(1'b0, 2'd0, 2'd0, 32'h0, {8'd3, 8'd2, NEVER, 8'd1}, 32'h0, 32'h0, 32'h0,
                0, TO + 1, 4'b0010, "set_wins_clr");
        pulse_clr(4'b0100);
        n_checks++;
        if (bus.ch_fail !== model_fail) begin n_fail++; $display("FAIL fail_clr: got %b want %b", bus.ch_fail, model_fail); end
    endtask

    task automatic test_random;
        logic             wr;
        logic [1:0]       mode, chan;
        logic [7:0]       b;
        logic [3:0][7:0]  dly, rx, dly2, rx2;
        int               r;
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            mode = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            chan = 2'($urandom_range(0, 3));
            b    = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                dly[i]  = ($urandom_range(0, 9) == 0) ? NEVER : 8'($urandom_range(1, TO));
                rx[i]   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : b;
                dly2[i] = ($urandom_range(0, 2) == 0 && dly[i] != NEVER) ? dly[i] + 8'($urandom_range(1, 3)) : 8'h0;
                rx2[i]  = 8'($urandom);
            end
            run_cmd(wr, mode, chan, $urandom, dly, rx, dly2, rx2, int'($urandom_range(0, 3)), 0, 4'h0, "random");
            if ($urandom_range(0, 2) == 0) pulse_clr(4'($urandom));
        end
    endtask

    initial begin
        wb_rst_i      = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_mode  = 2'd0;
        bus.cmd_chan  = 2'd0;
        bus.cmd_data  = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.ch_done   = 4'h0;
        bus.ch_rx     = 32'h0;
        bus.fail_clr  = 4'h0;
        test_reset;
        test_stripe_write;
        test_stripe_read_stagger;
        test_timeout;
        test_mirror_degraded;
        test_single_reserved;
        test_reset_mid;
        test_fail_clr;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
